// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter: IFU (read-only) and LSU (read/write) share one
// memory port, one outstanding transaction at a time, round-robin on conflict, with timeout.
module mem_arbiter #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req,
  input  logic [31:0] ifu_addr,
  output logic        ifu_gnt,
  output logic        ifu_rvalid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_gnt,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  output logic        mem_req,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_grant;
  logic               w_pick_lsu;
  logic               w_done;
  logic               w_tmo;
  logic               w_cnt_max;
  logic [31:0]        w_resp_data;

  logic               r_last_lsu;
  logic               r_own_lsu;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mem_req;
  logic               r_mem_wen;
  logic [31:0]        r_mem_addr;
  logic [31:0]        r_mem_wdata;
  logic [3:0]         r_mem_wmask;
  logic               r_ifu_rvalid;
  logic [31:0]        r_ifu_rdata;
  logic               r_lsu_rvalid;
  logic [31:0]        r_lsu_rdata;
  logic               r_err;

  // Writes complete with zero data; timed-out reads return the error pattern.
  function automatic logic [31:0] f_resp_data(input logic is_write, input logic timed_out,
                                              input logic [31:0] rdata);
    if (is_write)
      return 32'h0;
    else if (timed_out)
      return ERR_DATA;
    else
      return rdata;
  endfunction

  assign w_cnt_max   = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_resp_data = f_resp_data(r_mem_wen, w_tmo, mem_rdata);

  always_ff @(posedge clk) begin
    if (!rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Completion has priority over timeout when both land in the same cycle.
  always_comb begin
    w_next     = r_state;
    w_grant    = 1'b0;
    w_pick_lsu = 1'b0;
    w_done     = 1'b0;
    w_tmo      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rst && (ifu_req || lsu_req)) begin
          w_grant    = 1'b1;
          w_pick_lsu = lsu_req && (!ifu_req || !r_last_lsu);
          w_next     = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack && mem_rvalid) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end else if (w_cnt_max) begin
          w_tmo  = 1'b1;
          w_next = S_IDLE;
        end else if (mem_ack) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (mem_rvalid) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end else if (w_cnt_max) begin
          w_tmo  = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_lsu   <= 1'b0;
      r_own_lsu    <= 1'b0;
      r_cnt        <= '0;
      r_mem_req    <= 1'b0;
      r_mem_wen    <= 1'b0;
      r_mem_addr   <= 32'h0;
      r_mem_wdata  <= 32'h0;
      r_mem_wmask  <= 4'h0;
      r_ifu_rvalid <= 1'b0;
      r_ifu_rdata  <= 32'h0;
      r_lsu_rvalid <= 1'b0;
      r_lsu_rdata  <= 32'h0;
      r_err        <= 1'b0;
    end else begin
      r_ifu_rvalid <= 1'b0;
      r_lsu_rvalid <= 1'b0;
      r_err        <= 1'b0;
      if (w_grant) begin
        r_own_lsu   <= w_pick_lsu;
        r_last_lsu  <= w_pick_lsu;
        r_cnt       <= '0;
        r_mem_req   <= 1'b1;
        r_mem_wen   <= w_pick_lsu && lsu_wen;
        r_mem_addr  <= w_pick_lsu ? lsu_addr : ifu_addr;
        r_mem_wdata <= (w_pick_lsu && lsu_wen) ? lsu_wdata : 32'h0;
        r_mem_wmask <= (w_pick_lsu && lsu_wen) ? lsu_wmask : 4'h0;
      end else if (r_state != S_IDLE) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (r_state == S_REQ && mem_ack)
        r_mem_req <= 1'b0;
      if (w_done || w_tmo) begin
        r_mem_req <= 1'b0;
        r_err     <= w_tmo;
        if (r_own_lsu) begin
          r_lsu_rvalid <= 1'b1;
          r_lsu_rdata  <= w_resp_data;
        end else begin
          r_ifu_rvalid <= 1'b1;
          r_ifu_rdata  <= w_resp_data;
        end
      end
    end
  end

  assign ifu_gnt    = w_grant && !w_pick_lsu;
  assign lsu_gnt    = w_grant && w_pick_lsu;
  assign ifu_rvalid = r_ifu_rvalid;
  assign ifu_rdata  = r_ifu_rdata;
  assign lsu_rvalid = r_lsu_rvalid;
  assign lsu_rdata  = r_lsu_rdata;
  assign mem_req    = r_mem_req;
  assign mem_wen    = r_mem_wen;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_wmask  = r_mem_wmask;
  assign err        = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a small memory model answers requests and each
// grant pushes the expected response that the matching x_rvalid pulse must deliver.
module tb_mem_arbiter;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req, ifu_gnt, ifu_rvalid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req, lsu_wen, lsu_gnt, lsu_rvalid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req, mem_wen, mem_ack, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        err;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TMO), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
    .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_gnt(lsu_gnt),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .err(err)
  );

  typedef struct {
    logic        lsu;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  bit   glog[$];

  int n_vec = 0;
  int n_mis = 0;
  int n_rv  = 0;
  int cur_len = 0;
  int last_len = 0;

  logic        ifu_hold, lsu_hold, saw_ifu, saw_lsu;
  logic [31:0] x_addr, x_wdata;
  logic        x_wen;
  logic [3:0]  x_wmask;

  int          ack_delay, rsp_delay, m_cnt;
  logic        m_acked, spur;
  logic [31:0] m_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic dead(input logic [31:0] a);
    return a[31:28] == 4'hF;
  endfunction

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a == 32'h80000000) ? 32'h00000413 : (a ^ 32'h13579BDF);
  endfunction

  task automatic monitor();
    exp_t e;
    if (mem_req) cur_len++;
    else if (cur_len != 0) begin
      last_len = cur_len;
      cur_len  = 0;
    end
    check("rv_overlap", 32'(ifu_rvalid & lsu_rvalid), 32'h0);
    check("gnt_overlap", 32'(ifu_gnt & lsu_gnt), 32'h0);
    check("err_alone", 32'(err & ~(ifu_rvalid | lsu_rvalid)), 32'h0);
    if (ifu_rvalid || lsu_rvalid) begin
      n_rv++;
      if (sb.size() == 0) check("rv_unexpected", 32'h1, 32'h0);
      else begin
        e = sb.pop_front();
        check("rv_owner", 32'(lsu_rvalid), 32'(e.lsu));
        check("rdata", lsu_rvalid ? lsu_rdata : ifu_rdata, e.rdata);
        check("err", 32'(err), 32'(e.err));
      end
    end
    if (mem_req) begin
      check("mem_addr", mem_addr, x_addr);
      check("mem_wen", 32'(mem_wen), 32'(x_wen));
      check("mem_wmask", 32'(mem_wmask), 32'(x_wmask));
      if (x_wen) check("mem_wdata", mem_wdata, x_wdata);
    end
    if (ifu_gnt || lsu_gnt) begin
      glog.push_back(lsu_gnt);
      if (lsu_gnt) begin
        x_addr  = lsu_addr;
        x_wen   = lsu_wen;
        x_wdata = lsu_wdata;
        x_wmask = lsu_wen ? lsu_wmask : 4'h0;
        e.lsu   = 1'b1;
        e.err   = dead(lsu_addr);
        e.rdata = lsu_wen ? 32'h0 : (e.err ? 32'hDEADBEEF : rd_fn(lsu_addr));
        saw_lsu = 1'b1;
      end else begin
        x_addr  = ifu_addr;
        x_wen   = 1'b0;
        x_wdata = 32'h0;
        x_wmask = 4'h0;
        e.lsu   = 1'b0;
        e.err   = dead(ifu_addr);
        e.rdata = e.err ? 32'hDEADBEEF : rd_fn(ifu_addr);
        saw_ifu = 1'b1;
      end
      sb.push_back(e);
    end
  endtask

  task automatic mem_model();
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    if (!m_acked) begin
      if (mem_req && !dead(mem_addr)) begin
        if (m_cnt == ack_delay) begin
          mem_ack = 1'b1;
          m_acked = 1'b1;
          m_cnt   = 0;
          m_addr  = mem_addr;
          if (rsp_delay == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rd_fn(m_addr);
            m_acked    = 1'b0;
          end
        end else m_cnt++;
      end else m_cnt = 0;
    end else begin
      m_cnt++;
      if (m_cnt == rsp_delay) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd_fn(m_addr);
        m_acked    = 1'b0;
        m_cnt      = 0;
      end
    end
    if (spur) begin
      mem_ack    = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h12345678;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    mem_model();
    @(posedge clk);
    #1;
    if (saw_ifu && !ifu_hold) ifu_req = 1'b0;
    if (saw_lsu && !lsu_hold) lsu_req = 1'b0;
    saw_ifu = 1'b0;
    saw_lsu = 1'b0;
  endtask

  task automatic wait_rv(input string tag);
    int tgt = n_rv + 1;
    for (int i = 0; i < 40 && n_rv < tgt; i++) cyc();
    check(tag, 32'(n_rv >= tgt), 32'h1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (sb.size() != 0 || ifu_req || lsu_req); i++) cyc();
    check("drain", 32'(sb.size()), 32'h0);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_ctl"}, 32'({ifu_gnt, ifu_rvalid, lsu_gnt, lsu_rvalid, mem_req, mem_wen, err}), 32'h0);
    check({tag, "_mask"}, 32'(mem_wmask), 32'h0);
    check({tag, "_maddr"}, mem_addr, 32'h0);
    check({tag, "_mwdata"}, mem_wdata, 32'h0);
    check({tag, "_irdata"}, ifu_rdata, 32'h0);
    check({tag, "_lrdata"}, lsu_rdata, 32'h0);
  endtask

  task automatic issue_ifu(input logic [31:0] a);
    ifu_req  = 1'b1;
    ifu_addr = a;
  endtask

  task automatic issue_lsu(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] m);
    lsu_req   = 1'b1;
    lsu_wen   = w;
    lsu_addr  = a;
    lsu_wdata = d;
    lsu_wmask = m;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rv0;
    rst = 1'b0;
    ifu_req = 0; ifu_addr = 0; lsu_req = 0; lsu_wen = 0; lsu_addr = 0;
    lsu_wdata = 0; lsu_wmask = 0; mem_ack = 0; mem_rvalid = 0; mem_rdata = 0;
    ifu_hold = 0; lsu_hold = 0; saw_ifu = 0; saw_lsu = 0;
    x_addr = 0; x_wdata = 0; x_wen = 0; x_wmask = 0;
    ack_delay = 0; rsp_delay = 0; m_cnt = 0; m_acked = 0; spur = 0; m_addr = 0;

    // reset with both requesters already pending
    issue_ifu(32'h80000004);
    issue_lsu(1'b0, 32'h80001000, 32'h0, 4'h0);
    ifu_hold = 1'b1;
    lsu_hold = 1'b1;
    repeat (3) cyc();
    chk_zero("reset");
    rst = 1'b1;
    #1;
    check("first_conflict_lsu", 32'(lsu_gnt), 32'h1);
    check("first_conflict_ifu", 32'(ifu_gnt), 32'h0);
    for (int i = 0; i < 40 && glog.size() < 4; i++) cyc();
    check("rr_count", 32'(glog.size()), 32'h4);
    if (glog.size() >= 4) begin
      check("rr_g0", 32'(glog[0]), 32'h1);
      check("rr_g1", 32'(glog[1]), 32'h0);
      check("rr_g2", 32'(glog[2]), 32'h1);
      check("rr_g3", 32'(glog[3]), 32'h0);
    end
    ifu_req  = 1'b0;
    ifu_hold = 1'b0;
    lsu_hold = 1'b0;
    drain();
    check("rr_final_count", 32'(glog.size()), 32'h5);
    cyc();

    // IFU-only read, best-case latency
    issue_ifu(32'h80000000);
    #1;
    check("t1_gnt_c0", 32'(ifu_gnt), 32'h1);
    cyc();
    check("t1_memreq_c1", 32'(mem_req), 32'h1);
    check("t1_memaddr_c1", mem_addr, 32'h80000000);
    cyc();
    check("t1_rvalid_c2", 32'(ifu_rvalid), 32'h1);
    check("t1_rdata_c2", ifu_rdata, 32'h00000413);
    check("t1_err_c2", 32'(err), 32'h0);
    cyc();
    drain();

    // LSU write with delayed acknowledge
    ack_delay = 3;
    rsp_delay = 1;
    issue_lsu(1'b1, 32'h80001002, 32'h0000BEEF, 4'b1100);
    wait_rv("t3_wait");
    check("t3_memreq_len", 32'(last_len), 32'h4);
    ack_delay = 0;
    rsp_delay = 0;
    drain();

    // unresponsive memory, LSU waiting behind the stuck IFU read
    glog.delete();
    issue_ifu(32'hF0000100);
    cyc();
    cyc();
    issue_lsu(1'b0, 32'h80002000, 32'h0, 4'h0);
    wait_rv("t4_tmo_wait");
    check("t4_memreq_len", 32'(last_len), 32'(TMO));
    check("t4_next_gnt_cnt", 32'(glog.size()), 32'h2);
    if (glog.size() == 2) check("t4_next_is_lsu", 32'(glog[1]), 32'h1);
    wait_rv("t4_lsu_wait");
    drain();

    // reset while waiting for the response
    rsp_delay = 3;
    issue_lsu(1'b0, 32'h80003000, 32'h0, 4'h0);
    cyc();
    cyc();
    check("t5_in_resp", 32'(mem_req), 32'h0);
    rst = 1'b0;
    sb.delete();
    cyc();
    rst = 1'b1;
    chk_zero("t5_after_rst");
    rv0 = n_rv;
    repeat (5) cyc();
    check("t5_no_late_rv", 32'(n_rv), 32'(rv0));
    rsp_delay = 0;
    m_acked = 1'b0;
    m_cnt = 0;

    // stray memory handshakes while idle
    spur = 1'b1;
    rv0 = n_rv;
    repeat (3) cyc();
    spur = 1'b0;
    cyc();
    check("t6_no_spur_rv", 32'(n_rv), 32'(rv0));

    // mixed traffic with varied memory delays
    for (int k = 0; k < 8; k++) begin
      ack_delay = $urandom_range(0, 2);
      rsp_delay = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1)
        issue_lsu(1'($urandom_range(0, 1)), {16'h8000, 16'($urandom)}, $urandom, 4'($urandom));
      else
        issue_ifu({16'h8000, 16'($urandom)});
      wait_rv("mix_wait");
      cyc();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
